core_apb_master: RTL and testbench
==================================

Name: core_apb_master

Overview:
APB requester stage that sits directly upstream of the team's APB memory slave. It converts single-beat load/store requests from the RISC-V core's load/store unit into APB setup/access transfers and returns one response per request to the core. It adds alignment checking and an access-phase timeout so a stalled slave cannot hang the core.

Parameters:
DATA_LENGTH, 32, width of pwdata/prdata and core data buses
ADDRESS_LENGTH, 32, width of paddr and core address
TIMEOUT_CYCLES, 16, max ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
from_top_clk  in  1  single clock, rising edge
from_top_rst  in  1  asynchronous, active-high reset
core_req_valid  in  1  core request valid
core_req_ready  out  1  bridge can accept a request this cycle
core_req_write  in  1  1 = store, 0 = load
core_req_addr  in  ADDRESS_LENGTH  byte address
core_req_wdata  in  DATA_LENGTH  store data
core_req_strb  in  DATA_LENGTH/8  byte-lane write strobes
core_rsp_valid  out  1  one-cycle response pulse
core_rsp_rdata  out  DATA_LENGTH  load data; 0 for stores and errors
core_rsp_error  out  1  slave error, timeout or misalignment
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDRESS_LENGTH  APB address
pwdata  out  DATA_LENGTH  APB write data
pstrb  out  DATA_LENGTH/8  APB strobes; all 0 on reads
pready  in  1  slave ready
prdata  in  DATA_LENGTH  slave read data
pslverr  in  1  slave error

Behaviour:
- Clock and reset: one clock (from_top_clk); reset (from_top_rst) is asynchronous and active-high.
- Output registers: all outputs are registered except core_req_ready, which is decoded from state.
- Reset values: the state is IDLE; psel, penable, pwrite, paddr, pwdata, pstrb, core_rsp_valid, core_rsp_rdata, core_rsp_error and the timeout counter are all 0. Asserting reset mid-transfer drops psel and penable immediately and produces no response.
- States: IDLE, SETUP, ACCESS, RESP.
- core_req_ready is 1 in IDLE and in RESP, and 0 in SETUP and ACCESS. A request is accepted when core_req_valid && core_req_ready.
- IDLE/RESP, accepted and word-aligned (addr[1:0]==0): latch addr, write, wdata and strb into paddr, pwrite, pwdata and pstrb. For loads, pstrb=0. Next state is SETUP with psel=1, penable=0.
- IDLE/RESP, accepted and misaligned: no APB transfer is issued. Next state is RESP with core_rsp_error=1 and core_rsp_rdata=0.
- SETUP: advance unconditionally to ACCESS with psel=1, penable=1. Clear the timeout counter.
- ACCESS with pready=1: go to RESP and drop psel/penable to 0. Set core_rsp_error=pslverr. Set core_rsp_rdata=prdata for an error-free load, otherwise 0.
- ACCESS with pready=0: stay in ACCESS and increment the counter. paddr, pwdata, pwrite and pstrb stay stable.
- Timeout: when TIMEOUT_CYCLES≠0, the counter equals TIMEOUT_CYCLES and pready=0, abort. Drop psel/penable, go to RESP, set core_rsp_error=1 and core_rsp_rdata=0.
- Counter: width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- RESP: core_rsp_valid=1 for exactly one cycle. The response is not back-pressured. Next state is SETUP (or RESP for a misaligned request) if a new request is accepted in this cycle, else IDLE.
- Response clearing: core_rsp_valid returns to 0 in the cycle after RESP; core_rsp_rdata and core_rsp_error hold until the next response.
- Latency: with a zero-wait slave, the response arrives 3 cycles after acceptance (SETUP, ACCESS, RESP). Back-to-back throughput is one transfer per 3 cycles.
- Bus guarantees: penable is never 1 without psel. psel is never asserted in IDLE or RESP.

Test Plan:
- Zero-wait write: addr=0x0000_0010, wdata=0xDEAD_BEEF, strb=0xF, pready=1 → SETUP at T+1 (psel=1, penable=0), ACCESS at T+2, core_rsp_valid at T+3 with error=0 and rdata=0.
- Read with 3 wait states: addr=0x20, prdata=0x1234_5678 with pready asserted on the 4th ACCESS cycle → paddr stable throughout, rsp_valid with rdata=0x1234_5678 and error=0.
- pslverr: read with pready=1 and pslverr=1 → rsp_error=1, rdata=0; the next request is accepted in the RESP cycle.
- Timeout: TIMEOUT_CYCLES=4, pready held 0 → psel drops after 5 ACCESS cycles, one rsp_valid with error=1; a subsequent normal write completes correctly.
- Misaligned: addr=0x0000_0013 → psel never asserts, rsp_valid after 1 cycle with error=1.
- Reset mid-ACCESS: assert from_top_rst asynchronously → psel/penable go to 0 without waiting for a clock edge, no rsp_valid, state IDLE and core_req_ready=1 after release.

Source files
------------

// File: rtl/core_apb_master.sv
// APB requester: turns single-beat core load/store requests into APB setup/access
// transfers, with alignment checking and an access-phase timeout.
//   state  | meaning
//   IDLE   | no transfer, ready for a request
//   SETUP  | APB setup phase (psel=1, penable=0)
//   ACCESS | APB access phase, waiting for pready or timeout
//   RESP   | one-cycle response to the core, ready for a request
module core_apb_master #(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      from_top_clk,
  input  logic                      from_top_rst,
  input  logic                      core_req_valid,
  output logic                      core_req_ready,
  input  logic                      core_req_write,
  input  logic [ADDRESS_LENGTH-1:0] core_req_addr,
  input  logic [DATA_LENGTH-1:0]    core_req_wdata,
  input  logic [DATA_LENGTH/8-1:0]  core_req_strb,
  output logic                      core_rsp_valid,
  output logic [DATA_LENGTH-1:0]    core_rsp_rdata,
  output logic                      core_rsp_error,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRESS_LENGTH-1:0] paddr,
  output logic [DATA_LENGTH-1:0]    pwdata,
  output logic [DATA_LENGTH/8-1:0]  pstrb,
  input  logic                      pready,
  input  logic [DATA_LENGTH-1:0]    prdata,
  input  logic                      pslverr
);

  // A zero TIMEOUT_CYCLES still needs a legal one-bit counter.
  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             aligned;
  logic             timed_out;

  assign core_req_ready = (state == ST_IDLE) || (state == ST_RESP);
  assign accept         = core_req_valid && core_req_ready;
  assign aligned        = (core_req_addr[1:0] == 2'b00);
  assign timed_out      = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LIMIT);

  always_ff @(posedge from_top_clk or posedge from_top_rst) begin
    if (from_top_rst) begin
      state          <= ST_IDLE;
      psel           <= 1'b0;
      penable        <= 1'b0;
      pwrite         <= 1'b0;
      paddr          <= '0;
      pwdata         <= '0;
      pstrb          <= '0;
      core_rsp_valid <= 1'b0;
      core_rsp_rdata <= '0;
      core_rsp_error <= 1'b0;
      wait_cnt       <= '0;
    end else begin
      core_rsp_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (accept && aligned) begin
            state   <= ST_SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            paddr   <= core_req_addr;
            pwrite  <= core_req_write;
            pwdata  <= core_req_wdata;
            pstrb   <= core_req_write ? core_req_strb : '0;
          end else if (accept) begin
            // Misaligned: answer directly without touching the bus.
            state          <= ST_RESP;
            core_rsp_valid <= 1'b1;
            core_rsp_error <= 1'b1;
            core_rsp_rdata <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          state    <= ST_ACCESS;
          penable  <= 1'b1;
          wait_cnt <= '0;
        end
        ST_ACCESS: begin
          if (pready) begin
            state          <= ST_RESP;
            psel           <= 1'b0;
            penable        <= 1'b0;
            core_rsp_valid <= 1'b1;
            core_rsp_error <= pslverr;
            core_rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
          end else if (timed_out) begin
            state          <= ST_RESP;
            psel           <= 1'b0;
            penable        <= 1'b0;
            core_rsp_valid <= 1'b1;
            core_rsp_error <= 1'b1;
            core_rsp_rdata <= '0;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_apb_master.sv
// Randomized bench for core_apb_master: a behavioural slave plus a per-transaction
// reference model predicting latency, error and read data.
module tb_core_apb_master;
  localparam int T = 4;

  logic        from_top_clk = 1'b0;
  logic        from_top_rst = 1'b1;
  logic        core_req_valid = 1'b0;
  logic        core_req_ready;
  logic        core_req_write = 1'b0;
  logic [31:0] core_req_addr = '0;
  logic [31:0] core_req_wdata = '0;
  logic [3:0]  core_req_strb = '0;
  logic        core_rsp_valid;
  logic [31:0] core_rsp_rdata;
  logic        core_rsp_error;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        pslverr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_rdata = '0;
  logic        last_error = 1'b0;

  core_apb_master #(.DATA_LENGTH(32), .ADDRESS_LENGTH(32), .TIMEOUT_CYCLES(T)) dut (
    .from_top_clk(from_top_clk), .from_top_rst(from_top_rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_write(core_req_write), .core_req_addr(core_req_addr),
    .core_req_wdata(core_req_wdata), .core_req_strb(core_req_strb),
    .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
    .core_rsp_error(core_rsp_error),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr)
  );

  always #5 from_top_clk = ~from_top_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge where the response is visible,
  // so back-to-back calls issue the next request in the RESP cycle.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int waits, input bit slverr,
                        input logic [31:0] rd);
    bit          mis;
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_strb;
    int          lat = 0;
    int          acc = 0;
    int          viol = 0;
    bit          got = 0;
    bit          apb_seen = 0;

    mis      = (addr[1:0] != 2'b00);
    exp_strb = wr ? strb : 4'h0;
    exp_lat  = mis ? 1 : 3 + ((waits < T) ? waits : T);
    exp_err  = mis || (waits > T) || slverr;
    exp_rd   = (!exp_err && !wr) ? rd : 32'h0;

    check("req_ready", core_req_ready, 1);
    core_req_valid = 1'b1;
    core_req_write = wr;
    core_req_addr  = addr;
    core_req_wdata = wdata;
    core_req_strb  = strb;
    @(posedge from_top_clk);
    while (!got && lat < 40) begin
      @(negedge from_top_clk);
      lat++;
      core_req_valid = 1'b0;
      if (penable && !psel) viol++;
      if (psel) begin
        apb_seen = 1;
        if (paddr !== addr || pwrite !== wr || pstrb !== exp_strb) viol++;
        if (wr && pwdata !== wdata) viol++;
      end
      if (psel && penable) begin
        acc++;
        pready = (acc == waits + 1);
      end else begin
        pready = 1'b0;
      end
      prdata  = rd;
      pslverr = slverr;
      if (core_rsp_valid) got = 1;
    end
    check("rsp_seen", got, 1);
    check("latency", lat, exp_lat);
    check("rsp_error", core_rsp_error, exp_err);
    check("rsp_rdata", core_rsp_rdata, exp_rd);
    check("bus_viol", viol, 0);
    check("apb_issued", apb_seen, !mis);
    last_rdata = exp_rd;
    last_error = exp_err;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge from_top_clk);
      check("idle_rsp_valid", core_rsp_valid, 0);
      check("idle_psel", psel, 0);
      check("idle_hold_rdata", core_rsp_rdata, last_rdata);
      check("idle_hold_error", core_rsp_error, last_error);
    end
  endtask

  initial begin
    @(negedge from_top_clk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", core_rsp_valid, 0);
    check("rst_ready", core_req_ready, 1);
    check("rst_rdata", core_rsp_rdata, 0);
    from_top_rst = 1'b0;
    idle(2);

    // zero-wait write
    do_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0);
    idle(1);
    // read with 3 wait states
    do_txn(0, 32'h0000_0020, 32'h0, 4'h0, 3, 0, 32'h1234_5678);
    idle(1);
    // slave error, next request taken in the RESP cycle
    do_txn(0, 32'h0000_0024, 32'h0, 4'h0, 0, 1, 32'hCAFE_0000);
    do_txn(1, 32'h0000_0028, 32'h1111_2222, 4'h3, 0, 0, 32'h0);
    // pready never comes: abort after T+1 access cycles
    do_txn(0, 32'h0000_0030, 32'h0, 4'h0, 1000, 0, 32'h5555_AAAA);
    do_txn(1, 32'h0000_0034, 32'h3333_4444, 4'hF, 0, 0, 32'h0);
    // exactly at the timeout limit still completes
    do_txn(0, 32'h0000_0038, 32'h0, 4'h0, T, 0, 32'h7777_8888);
    // misaligned
    do_txn(1, 32'h0000_0013, 32'h9999_9999, 4'hF, 0, 0, 32'h0);
    do_txn(0, 32'h0000_0042, 32'h0, 4'h0, 0, 0, 32'h0);
    idle(2);

    // reset mid-ACCESS
    core_req_valid = 1'b1;
    core_req_write = 1'b0;
    core_req_addr  = 32'h0000_0040;
    @(posedge from_top_clk);
    @(negedge from_top_clk);
    core_req_valid = 1'b0;
    @(negedge from_top_clk);
    check("pre_rst_access", {psel, penable}, 2'b11);
    #2 from_top_rst = 1'b1;
    #1;
    check("async_rst_psel", psel, 0);
    check("async_rst_penable", penable, 0);
    @(negedge from_top_clk);
    check("rst_no_rsp", core_rsp_valid, 0);
    from_top_rst = 1'b0;
    last_rdata = 32'h0;
    last_error = 1'b0;
    check("post_rst_ready", core_req_ready, 1);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      bit          wr;
      logic [31:0] addr;
      int          waits;
      bit          se;
      wr    = $urandom_range(0, 1);
      addr  = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      waits = $urandom_range(0, T + 2);
      se    = ($urandom_range(0, 4) == 0);
      do_txn(wr, addr, $urandom, 4'($urandom), waits, se, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
